// File: rtl/control_unit_mi.sv
// control_unit_mi
//   Multi-cycle sequencer for datapath_mi. Walks FETCH -> EXEC (-> MEM)
//   and decodes the instruction register into the datapath control word.
//   The control word and K are combinational from the current state, I
//   and alu_status, so they apply to the cycle they appear in.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   run          start request, only looked at in IDLE
//   I            instruction register contents from datapath_mi
//   alu_status   {N,Z,C,V} from datapath_mi
//   control_word {sl,il,pcl,mr,mw,b_sel,a_sel,en_alu,ci,FS[2:0],rw,SB,SA,DA}
//   K            8-bit immediate to the datapath
//   halted       set by HALT, cleared on the next IDLE->FETCH
//   state        current FSM state (debug)
module control_unit_mi #(
  parameter bit RESET_RUN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] I,
  input  logic [3:0]  alu_status,
  output logic [21:0] control_word,
  output logic [7:0]  K,
  output logic        halted,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    MEM   = 2'b11
  } state_t;

  // Field layout mirrors control_word bit order, MSB first.
  typedef struct packed {
    logic       sl;
    logic       il;
    logic       pcl;
    logic       mr;
    logic       mw;
    logic       b_sel;
    logic       a_sel;
    logic       en_alu;
    logic       ci;
    logic [2:0] fs;
    logic       rw;
    logic [2:0] sb;
    logic [2:0] sa;
    logic [2:0] da;
  } ctrl_t;

  localparam logic [2:0] FS_AND  = 3'b000;
  localparam logic [2:0] FS_OR   = 3'b001;
  localparam logic [2:0] FS_ADD  = 3'b010;
  localparam logic [2:0] FS_SUB  = 3'b011;
  localparam logic [2:0] FS_SL   = 3'b100;
  localparam logic [2:0] FS_SR   = 3'b101;
  localparam logic [2:0] FS_XOR  = 3'b110;
  localparam logic [2:0] FS_PASS = 3'b111;

  state_t     cur, nxt;
  ctrl_t      cw;
  logic [7:0] k_c;
  logic       first_clk;   // high only in the first cycle after reset
  logic       halt_set;
  logic       go;
  logic       taken;

  wire [3:0] op    = I[15:12];
  wire [2:0] f_da  = I[11:9];
  wire [2:0] f_sa  = I[8:6];
  wire [2:0] f_sb  = I[5:3];
  wire [3:0] cond  = I[11:8];
  wire       st_n  = alu_status[3];
  wire       st_z  = alu_status[2];
  wire       st_c  = alu_status[1];
  wire       st_v  = alu_status[0];

  assign go = run || (RESET_RUN && first_clk);

  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0: taken = 1'b1;
      4'h1: taken = st_z;
      4'h2: taken = !st_z;
      4'h3: taken = st_c;
      4'h4: taken = !st_c;
      4'h5: taken = st_n;
      4'h6: taken = !st_n;
      4'h7: taken = st_v;
      4'h8: taken = !st_v;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    cw       = '0;
    k_c      = '0;
    nxt      = cur;
    halt_set = 1'b0;
    case (cur)
      IDLE: if (go) nxt = FETCH;
      FETCH: begin
        // PC <- PC + 1 through the ALU while IR loads.
        cw.il = 1'b1; cw.pcl = 1'b1; cw.a_sel = 1'b1; cw.en_alu = 1'b1;
        cw.ci = 1'b1; cw.fs = FS_ADD; cw.sb = 3'b111;
        nxt = EXEC;
      end
      EXEC: begin
        nxt = FETCH;
        case (op)
          4'h0: ;
          4'h1: begin
            cw.b_sel = 1'b1; cw.en_alu = 1'b1; cw.fs = FS_PASS;
            cw.rw = 1'b1; cw.da = f_da; k_c = I[7:0];
          end
          4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            cw.en_alu = 1'b1; cw.rw = 1'b1; cw.sl = I[0];
            cw.da = f_da; cw.sa = f_sa; cw.sb = f_sb;
            case (op)
              4'h2: cw.fs = FS_ADD;
              4'h3: begin cw.fs = FS_SUB; cw.ci = 1'b1; end
              4'h4: cw.fs = FS_AND;
              4'h5: cw.fs = FS_OR;
              4'h6: cw.fs = FS_XOR;
              4'h7: cw.fs = FS_SL;
              default: cw.fs = FS_SR;
            endcase
          end
          4'h9: begin
            cw.mr = 1'b1; k_c = I[7:0];
            nxt = MEM;
          end
          4'hA: begin
            cw.mw = 1'b1; cw.sb = f_da; k_c = I[7:0];
          end
          4'hB: begin
            cw.pcl = 1'b1; cw.a_sel = 1'b1; cw.b_sel = 1'b1;
            cw.en_alu = 1'b1; cw.fs = FS_ADD; k_c = I[7:0];
          end
          4'hC: begin
            cw.pcl = 1'b1; cw.en_alu = 1'b1; cw.fs = FS_OR;
            cw.sa = f_da; cw.sb = f_da;
          end
          4'hD: if (taken) begin
            cw.pcl = 1'b1; cw.a_sel = 1'b1; cw.b_sel = 1'b1;
            cw.en_alu = 1'b1; cw.fs = FS_ADD; k_c = I[7:0];
          end
          4'hE: begin
            // PC already points at the next instruction; add with SB=7.
            cw.a_sel = 1'b1; cw.en_alu = 1'b1; cw.fs = FS_ADD;
            cw.sb = 3'b111; cw.rw = 1'b1; cw.da = f_da;
          end
          default: begin
            halt_set = 1'b1;
            nxt = IDLE;
          end
        endcase
      end
      MEM: begin
        cw.mr = 1'b1; cw.rw = 1'b1; cw.da = f_da; k_c = I[7:0];
        nxt = FETCH;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= IDLE;
      halted    <= 1'b0;
      first_clk <= 1'b1;
    end else begin
      cur       <= nxt;
      first_clk <= 1'b0;
      if (halt_set)
        halted <= 1'b1;
      else if (cur == IDLE && go)
        halted <= 1'b0;
    end
  end

  assign control_word = cw;
  assign K            = k_c;
  assign state        = cur;

endmodule
